bit_counter_target: RTL and testbench
=====================================

# bit_counter_target

Target-side HDR-DDR bit counter. Tracks the position of each bit within a 20-bit DDR word (2 preamble, 16 data, 2 parity) from pre-detected SCL edge strobes. It sits directly upstream of the target frame counter, which decrements its byte budget on o_cnt_bit_count 6/16 qualified by o_bitcnt_toggle. It also drives word-phase flags and a completed-word count for the target control FSM.

## Interface
- WORD_BITS, 20: bits per DDR word; the bit index wraps after WORD_BITS-1.
- PRE_BITS, 2: preamble bits at indices 0..PRE_BITS-1.
- PAR_BITS, 2: parity bits at indices WORD_BITS-PAR_BITS..WORD_BITS-1.

Ports:
- i_bitcnt_clk  in  1  system clock; single clock domain.
- i_bitcnt_rst  in  1  reset; synchronous, active-high.
- i_bitcnt_en  in  1  enable from target FSM; low clears the count and returns to IDLE.
- i_scl_pos_edge  in  1  one-cycle strobe, SCL rising edge (synchronous to i_bitcnt_clk).
- i_scl_neg_edge  in  1  one-cycle strobe, SCL falling edge.
- o_cnt_bit_count  out  6  index of the bit sampled on the most recent edge, 0..WORD_BITS-1.
- o_bitcnt_toggle  out  1  one-cycle strobe; high exactly in the cycle o_cnt_bit_count takes a new value.
- o_bitcnt_preamble  out  1  current index is in the preamble.
- o_bitcnt_data  out  1  current index is in the data field.
- o_bitcnt_parity  out  1  current index is in the parity field.
- o_bitcnt_word_done  out  1  one-cycle strobe with the toggle that counts the last bit of a word.
- o_bitcnt_word_cnt  out  16  completed words since enable; saturates at 16'hFFFF.
- o_bitcnt_err  out  1  sticky; both edge strobes were seen in the same cycle.

## Operation
- States: IDLE, ARMED, RUN, ERR.
- IDLE: all outputs 0. When i_bitcnt_en = 1, go to ARMED on the next edge of i_bitcnt_clk.
- ARMED: waits for the first edge. An edge is either strobe high, with the other strobe low.
  - On the first edge: o_cnt_bit_count = 0, o_bitcnt_toggle = 1, go to RUN.
- RUN: on each edge, o_cnt_bit_count = (count == WORD_BITS-1) ? 0 : count+1, and o_bitcnt_toggle = 1.
  - The edge that counts bit WORD_BITS-1 also pulses o_bitcnt_word_done and increments o_bitcnt_word_cnt (no increment at 16'hFFFF).
- Both strobes high in one cycle, in ARMED or RUN:
  - Go to ERR and set o_bitcnt_err = 1.
  - No toggle and no count change.
- ERR: count and word count are frozen and toggle is held 0. The state is left only when i_bitcnt_en = 0.
- i_bitcnt_en = 0 in any state: next cycle go to IDLE. Count, word count, toggle, flags and err are all cleared. Strobes in that cycle are ignored.
- Phase flags are decoded from the registered count, so they update in the same cycle as the count:
  - preamble: count < PRE_BITS.
  - parity: count >= WORD_BITS-PAR_BITS.
  - data: otherwise.
  - All flags are 0 in IDLE and ARMED.
- Width rule: count is 6 bits; WORD_BITS must be <= 63.

## Timing
- Reset (i_bitcnt_rst = 1 at a clock edge) puts the block in IDLE with every output 0. Reset has priority over enable and the strobes.
- Reset mid-word: the next cycle shows all outputs 0. After reset releases with enable high, one cycle is spent in IDLE, then ARMED.
- Latency: strobe in cycle N, so o_cnt_bit_count, o_bitcnt_toggle, flags and word_done are registered and valid in cycle N+1.
- The toggle is never high for two consecutive cycles unless strobes arrive in consecutive cycles. Each accepted strobe produces exactly one toggle.
- Strobes in the IDLE cycle right after enable rises are ignored. The first counted edge must arrive with the block in ARMED.
- Downstream use: the frame counter samples count and toggle in the same cycle. Count 6 and count 16 each produce exactly one toggle-qualified cycle per word.

## Test plan
- Reset then enable, 20 alternating pos/neg strobes spaced 3 clocks apart:
  - count steps 0..19, with 20 toggles.
  - word_done pulses once, on the count = 19 cycle.
  - word_cnt = 1.
  - preamble flag high at counts 0-1, data at 2-17, parity at 18-19.
- 45 strobes: count wraps 19 -> 0 twice, word_cnt = 2, and the final count = 4.
- Both strobes in one cycle at count 7:
  - err = 1, count stays 7, no toggle.
  - Further strobes are ignored.
  - Dropping en clears err and the count the next cycle.
- Reset asserted at count 12 with a strobe in the same cycle: all outputs 0 the next cycle and no toggle.
- Preload word_cnt to 16'hFFFF via 65535 words (or force), then complete one more word: word_cnt stays 16'hFFFF and word_done still pulses.
- en deasserted at count 5 with a strobe in the same cycle:
  - Next cycle is IDLE with all outputs 0.
  - Re-enable: the first edge gives count 0 with toggle.

Source files
------------

// File: rtl/bit_counter_target_if.sv
// Edge-strobe inputs and word-position outputs of the HDR-DDR target bit counter.
// master drives enable/strobes (target control side), slave is the counter.
interface bit_counter_target_if;
  logic        i_bitcnt_en;
  logic        i_scl_pos_edge;
  logic        i_scl_neg_edge;
  logic [5:0]  o_cnt_bit_count;
  logic        o_bitcnt_toggle;
  logic        o_bitcnt_preamble;
  logic        o_bitcnt_data;
  logic        o_bitcnt_parity;
  logic        o_bitcnt_word_done;
  logic [15:0] o_bitcnt_word_cnt;
  logic        o_bitcnt_err;

  modport master (
    output i_bitcnt_en, i_scl_pos_edge, i_scl_neg_edge,
    input  o_cnt_bit_count, o_bitcnt_toggle, o_bitcnt_preamble, o_bitcnt_data,
           o_bitcnt_parity, o_bitcnt_word_done, o_bitcnt_word_cnt, o_bitcnt_err
  );

  modport slave (
    input  i_bitcnt_en, i_scl_pos_edge, i_scl_neg_edge,
    output o_cnt_bit_count, o_bitcnt_toggle, o_bitcnt_preamble, o_bitcnt_data,
           o_bitcnt_parity, o_bitcnt_word_done, o_bitcnt_word_cnt, o_bitcnt_err
  );
endinterface

// File: rtl/bit_counter_target.sv
// Target-side HDR-DDR bit counter: tracks bit position inside a 20-bit DDR word
// from SCL edge strobes, with word-phase flags and a saturating completed-word count.
//
// state | meaning
// IDLE  | disabled or just enabled; all outputs 0, strobes ignored
// ARMED | enabled, waiting for the first edge of a word (count reads 0, flags 0)
// RUN   | counting edges; index wraps after WORD_BITS-1
// ERR   | both strobes seen together; everything frozen until enable drops
module bit_counter_target #(
  parameter int WORD_BITS = 20,
  parameter int PRE_BITS  = 2,
  parameter int PAR_BITS  = 2
) (
  input  logic                  i_bitcnt_clk,
  input  logic                  i_bitcnt_rst,
  bit_counter_target_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2,
    ST_ERR   = 2'd3
  } state_t;

  // WORD_BITS must stay <= 63 so every index fits the 6-bit count.
  localparam logic [5:0] LAST_IDX  = 6'(WORD_BITS - 1);
  localparam logic [5:0] PRE_END   = 6'(PRE_BITS);
  localparam logic [5:0] PAR_START = 6'(WORD_BITS - PAR_BITS);

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        toggle_q, toggle_d;
  logic        done_q, done_d;
  logic [15:0] word_cnt_q, word_cnt_d;
  logic        err_q, err_d;

  logic one_edge, both_edges;
  assign one_edge   = bus.i_scl_pos_edge ^ bus.i_scl_neg_edge;
  assign both_edges = bus.i_scl_pos_edge & bus.i_scl_neg_edge;

  always_ff @(posedge i_bitcnt_clk) begin
    if (i_bitcnt_rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      toggle_q   <= 1'b0;
      done_q     <= 1'b0;
      word_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      toggle_q   <= toggle_d;
      done_q     <= done_d;
      word_cnt_q <= word_cnt_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    toggle_d   = 1'b0;
    done_d     = 1'b0;
    word_cnt_d = word_cnt_q;
    err_d      = err_q;

    if (!bus.i_bitcnt_en) begin
      state_d    = ST_IDLE;
      cnt_d      = '0;
      word_cnt_d = '0;
      err_d      = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_ARMED;
        ST_ARMED, ST_RUN: begin
          if (both_edges) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end else if (one_edge) begin
            state_d  = ST_RUN;
            toggle_d = 1'b1;
            if (state_q == ST_ARMED || cnt_q == LAST_IDX) cnt_d = '0;
            else                                           cnt_d = cnt_q + 6'd1;
            // Word completes on the edge that samples its last bit.
            if (cnt_d == LAST_IDX) begin
              done_d = 1'b1;
              if (word_cnt_q != 16'hFFFF) word_cnt_d = word_cnt_q + 16'd1;
            end
          end
        end
        ST_ERR:  state_d = ST_ERR;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Flags follow the registered index; the 0 held in ARMED is not a real bit.
  logic counting;
  logic in_pre, in_par;
  assign counting = (state_q == ST_RUN) || (state_q == ST_ERR);
  assign in_pre   = counting && (cnt_q < PRE_END);
  assign in_par   = counting && (cnt_q >= PAR_START);

  assign bus.o_cnt_bit_count    = cnt_q;
  assign bus.o_bitcnt_toggle    = toggle_q;
  assign bus.o_bitcnt_preamble  = in_pre;
  assign bus.o_bitcnt_parity    = in_par;
  assign bus.o_bitcnt_data      = counting && !in_pre && !in_par;
  assign bus.o_bitcnt_word_done = done_q;
  assign bus.o_bitcnt_word_cnt  = word_cnt_q;
  assign bus.o_bitcnt_err       = err_q;

endmodule

// File: tb/tb_bit_counter_target.sv
// Directed bench for bit_counter_target: expected toggles are queued by a reference
// model when a strobe is driven and checked by a monitor when the toggle appears.
module tb_bit_counter_target;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bit_counter_target_if bus ();

  bit_counter_target dut (
    .i_bitcnt_clk (clk),
    .i_bitcnt_rst (rst),
    .bus          (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit mon_on = 1'b0;

  logic [31:0] sb_q[$];

  bit          m_started;
  bit          m_err;
  int          m_cnt;
  int          m_wc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {4'd0, bus.o_cnt_bit_count, bus.o_bitcnt_toggle, bus.o_bitcnt_preamble,
            bus.o_bitcnt_data, bus.o_bitcnt_parity, bus.o_bitcnt_word_done,
            bus.o_bitcnt_word_cnt, bus.o_bitcnt_err};
  endfunction

  function automatic logic [31:0] pack_exp(input int cnt, input bit done, input int wc);
    logic pre, par, dat;
    logic [5:0]  c6;
    logic [15:0] w16;
    pre = (cnt < 2);
    par = (cnt >= 18);
    dat = !pre && !par;
    c6  = 6'(cnt);
    w16 = 16'(wc);
    return {6'd0, c6, pre, dat, par, done, w16};
  endfunction

  task automatic model_clear();
    m_started = 1'b0;
    m_err     = 1'b0;
    m_cnt     = 0;
    m_wc      = 0;
  endtask

  task automatic model_step(input bit p, input bit n);
    bit done;
    if (p && n) m_err = 1'b1;
    else if ((p ^ n) && !m_err) begin
      if (!m_started) m_cnt = 0;
      else            m_cnt = (m_cnt == 19) ? 0 : m_cnt + 1;
      m_started = 1'b1;
      done = (m_cnt == 19);
      if (done && m_wc != 16'hFFFF) m_wc++;
      sb_q.push_back(pack_exp(m_cnt, done, m_wc));
    end
  endtask

  // Called at a negedge; drives the strobes for one clock, then idles gap clocks.
  task automatic strobe(input bit p, input bit n, input int gap);
    bus.i_scl_pos_edge = p;
    bus.i_scl_neg_edge = n;
    model_step(p, n);
    @(negedge clk);
    bus.i_scl_pos_edge = 1'b0;
    bus.i_scl_neg_edge = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  // Drop enable for one cycle, confirm cleared outputs, re-enable and land in ARMED.
  task automatic restart(input string tag);
    bus.i_bitcnt_en = 1'b0;
    @(negedge clk);
    chk(tag, all_outs(), 32'd0);
    model_clear();
    bus.i_bitcnt_en = 1'b1;
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      if (bus.o_bitcnt_toggle === 1'b1) begin
        if (sb_q.size() == 0) chk("unexpected_toggle", 32'd1, 32'd0);
        else chk("toggle_fields",
                 {6'd0, bus.o_cnt_bit_count, bus.o_bitcnt_preamble, bus.o_bitcnt_data,
                  bus.o_bitcnt_parity, bus.o_bitcnt_word_done, bus.o_bitcnt_word_cnt},
                 sb_q.pop_front());
      end else begin
        chk("done_without_toggle", 32'(bus.o_bitcnt_word_done), 32'd0);
      end
    end
  end

  initial begin
    bus.i_bitcnt_en    = 1'b0;
    bus.i_scl_pos_edge = 1'b0;
    bus.i_scl_neg_edge = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_outputs", all_outs(), 32'd0);
    mon_on = 1'b1;

    // One word, alternating edges three clocks apart; a strobe during IDLE is ignored.
    bus.i_bitcnt_en    = 1'b1;
    bus.i_scl_pos_edge = 1'b1;
    @(negedge clk);
    bus.i_scl_pos_edge = 1'b0;
    chk("armed_outputs", all_outs(), 32'd0);
    for (int i = 0; i < 20; i++) strobe(i % 2 == 0, i % 2 == 1, 2);
    chk("word1_count", 32'(bus.o_cnt_bit_count), 32'd19);
    chk("word1_wc", 32'(bus.o_bitcnt_word_cnt), 32'd1);
    chk("word1_q_empty", 32'(sb_q.size()), 32'd0);

    // 45 edges, mixing back-to-back and spaced strobes.
    restart("en_drop_clear1");
    for (int i = 0; i < 45; i++) strobe(i % 2 == 1, i % 2 == 0, i % 3 == 0 ? 0 : 1);
    chk("wrap_count", 32'(bus.o_cnt_bit_count), 32'd4);
    chk("wrap_wc", 32'(bus.o_bitcnt_word_cnt), 32'd2);
    chk("wrap_q_empty", 32'(sb_q.size()), 32'd0);

    // Collision at count 7 freezes everything until enable drops.
    restart("en_drop_clear2");
    for (int i = 0; i < 8; i++) strobe(1'b1, 1'b0, 1);
    chk("pre_err_count", 32'(bus.o_cnt_bit_count), 32'd7);
    strobe(1'b1, 1'b1, 0);
    chk("err_set", 32'(bus.o_bitcnt_err), 32'd1);
    chk("err_count_hold", 32'(bus.o_cnt_bit_count), 32'd7);
    chk("err_no_toggle", 32'(bus.o_bitcnt_toggle), 32'd0);
    for (int i = 0; i < 3; i++) strobe(i % 2 == 0, i % 2 == 1, 1);
    chk("err_frozen_count", 32'(bus.o_cnt_bit_count), 32'd7);
    chk("err_sticky", 32'(bus.o_bitcnt_err), 32'd1);
    restart("err_cleared");

    // Reset at count 12 with a coincident strobe; strobe right after release is ignored.
    for (int i = 0; i < 13; i++) strobe(1'b0, 1'b1, 1);
    chk("pre_rst_count", 32'(bus.o_cnt_bit_count), 32'd12);
    rst = 1'b1;
    bus.i_scl_pos_edge = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_word", all_outs(), 32'd0);
    model_clear();
    @(negedge clk);
    bus.i_scl_pos_edge = 1'b0;
    chk("rst_idle_strobe_ignored", all_outs(), 32'd0);
    strobe(1'b0, 1'b1, 1);
    chk("post_rst_first", 32'(bus.o_cnt_bit_count), 32'd0);

    // Word-count saturation from a preloaded 16'hFFFE.
    force dut.word_cnt_q = 16'hFFFE;
    @(negedge clk);
    release dut.word_cnt_q;
    m_wc = 16'hFFFE;
    chk("preload_wc", 32'(bus.o_bitcnt_word_cnt), 32'h0000FFFE);
    for (int i = 0; i < 39; i++) strobe(i % 2 == 0, i % 2 == 1, 0);
    @(negedge clk);
    chk("sat_wc", 32'(bus.o_bitcnt_word_cnt), 32'h0000FFFF);
    chk("sat_count", 32'(bus.o_cnt_bit_count), 32'd19);
    chk("sat_q_empty", 32'(sb_q.size()), 32'd0);

    // Enable drop at count 5 with a coincident strobe, then a fresh word.
    restart("en_drop_clear3");
    for (int i = 0; i < 6; i++) strobe(1'b1, 1'b0, 2);
    chk("pre_dis_count", 32'(bus.o_cnt_bit_count), 32'd5);
    bus.i_bitcnt_en    = 1'b0;
    bus.i_scl_pos_edge = 1'b1;
    @(negedge clk);
    bus.i_scl_pos_edge = 1'b0;
    chk("dis_with_strobe", all_outs(), 32'd0);
    model_clear();
    bus.i_bitcnt_en = 1'b1;
    @(negedge clk);
    strobe(1'b1, 1'b0, 1);
    chk("reenable_first", 32'(bus.o_cnt_bit_count), 32'd0);
    chk("final_q_empty", 32'(sb_q.size()), 32'd0);

    mon_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
